mc_mem_responder: RTL and testbench

//  Memory-controller-side responder for the AEMC request/response interface.

---
 rtl/mc_mem_responder.sv | 202 ++++++++++++++++++++
 tb/tb_mc_mem_responder.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_mem_responder.sv
// ---------------------------------------------------------------------------
// mc_mem_responder
//   Memory-controller-side responder for the AEMC request/response interface.
//   Requests (RD8 / WR8) are queued in order, serviced one at a time against
//   an internal store of 2^NAB 64-bit words, and answered with RD8_DATA or
//   WR_CMP carrying the request's rtnctl. Stand-in for the MC behind the cores.
//
//   Optional feature: define MC_RANDLAT_EN to add a per-request random 0..3
//   cycles to the service latency (8-bit LFSR, stepped on every pop).
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   base_addr         byte address of store word 0
//   mc_rq_*           request channel; scmd, size and flush are ignored
//   mc_rq_stall       registered back-pressure to the initiator
//   mem_gnt           combinational: request accepted this cycle
//   mc_rs_*           response channel, held stable while mc_rs_stall is high
//   mc_rs_stall       consumer back-pressure
//   err               sticky: a request was dropped (queue full or bad cmd)
// ---------------------------------------------------------------------------
module mc_mem_responder #(
   parameter int MC_RTNCTL_WIDTH = 32,
   parameter int NAB             = 6,
   parameter int QDEPTH          = 4,
   parameter int LAT             = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [47:0]                base_addr,
   input  logic                       mc_rq_vld,
   input  logic [2:0]                 mc_rq_cmd,
   input  logic [3:0]                 mc_rq_scmd,
   input  logic [47:0]                mc_rq_vadr,
   input  logic [1:0]                 mc_rq_size,
   input  logic [MC_RTNCTL_WIDTH-1:0] mc_rq_rtnctl,
   input  logic [63:0]                mc_rq_data,
   input  logic                       mc_rq_flush,
   output logic                       mc_rq_stall,
   output logic                       mem_gnt,
   output logic                       mc_rs_vld,
   output logic [2:0]                 mc_rs_cmd,
   output logic [3:0]                 mc_rs_scmd,
   output logic [MC_RTNCTL_WIDTH-1:0] mc_rs_rtnctl,
   output logic [63:0]                mc_rs_data,
   input  logic                       mc_rs_stall,
   output logic                       err
);

   localparam logic [2:0] AEMC_CMD_IDLE     = 3'd0;
   localparam logic [2:0] AEMC_CMD_RD8      = 3'd1;
   localparam logic [2:0] AEMC_CMD_WR8      = 3'd2;
   localparam logic [2:0] MCAE_CMD_RD8_DATA = 3'd2;
   localparam logic [2:0] MCAE_CMD_WR_CMP   = 3'd3;

   localparam int             QAW    = $clog2(QDEPTH);
   localparam logic [QAW:0]   QFULL  = (QAW+1)'(QDEPTH);
   localparam logic [QAW:0]   QHIWAT = (QAW+1)'(QDEPTH - 2);
   localparam logic [7:0]     LAT8   = 8'(LAT);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;
   state_t state;

   // request queue (data only, never reset)
   logic                       q_wr   [QDEPTH];
   logic [NAB-1:0]             q_idx  [QDEPTH];
   logic [63:0]                q_data [QDEPTH];
   logic [MC_RTNCTL_WIDTH-1:0] q_rtn  [QDEPTH];
   logic [63:0]                store  [2**NAB];

   logic [QAW-1:0]             wr_ptr, rd_ptr;
   logic [QAW:0]               count, count_next;
   logic [7:0]                 cnt, pop_lat;
   logic [47:0]                offset;
   logic [NAB-1:0]             rq_idx;
   logic                       cmd_ok, cmd_bad, full, drop, pop;
   logic [2:0]                 head_cmd;
   logic [63:0]                head_data;
   logic [MC_RTNCTL_WIDTH-1:0] head_rtn;
   logic [2:0]                 rsp_cmd_p1;
   logic [63:0]                rsp_data_p1;
   logic [MC_RTNCTL_WIDTH-1:0] rsp_rtn_p1;
   logic                       unused_ok;

   // Word index is taken modulo the store size; out-of-range addresses wrap.
   assign offset     = mc_rq_vadr - base_addr;
   assign rq_idx     = offset[NAB+2:3];
   assign cmd_ok     = (mc_rq_cmd == AEMC_CMD_RD8) || (mc_rq_cmd == AEMC_CMD_WR8);
   assign cmd_bad    = !cmd_ok && (mc_rq_cmd != AEMC_CMD_IDLE);
   assign full       = (count == QFULL);
   assign mem_gnt    = mc_rq_vld && cmd_ok && !full;
   assign drop       = mc_rq_vld && ((cmd_ok && full) || cmd_bad);
   // The head can leave the queue when the engine is idle or the current
   // response is being consumed this cycle.
   assign pop        = (count != '0) &&
                       ((state == S_IDLE) || ((state == S_RESP) && !mc_rs_stall));
   assign count_next = count + (QAW+1)'(mem_gnt) - (QAW+1)'(pop);

   assign head_cmd   = q_wr[rd_ptr] ? MCAE_CMD_WR_CMP : MCAE_CMD_RD8_DATA;
   assign head_data  = q_wr[rd_ptr] ? 64'd0 : store[q_idx[rd_ptr]];
   assign head_rtn   = q_rtn[rd_ptr];

   assign mc_rs_scmd = 4'd0;
   assign unused_ok  = ^{mc_rq_scmd, mc_rq_size, mc_rq_flush,
                         offset[47:NAB+3], offset[2:0]};

`ifdef MC_RANDLAT_EN
   logic [7:0] lfsr;

   assign pop_lat = LAT8 + {6'd0, lfsr[1:0]};

   // Fibonacci LFSR, x^8+x^6+x^5+x^4+1
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         lfsr <= 8'hA5;
      else if (pop)
         lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   end
`else
   assign pop_lat = LAT8;
`endif

   // ---- stage p0 -> p1: queue write, store access and response capture at pop
   // The store is accessed as the request leaves the queue, so a later RD8
   // always observes an earlier WR8 to the same word.
   always_ff @(posedge clk) begin
      if (mem_gnt) begin
         q_wr[wr_ptr]   <= (mc_rq_cmd == AEMC_CMD_WR8);
         q_idx[wr_ptr]  <= rq_idx;
         q_data[wr_ptr] <= mc_rq_data;
         q_rtn[wr_ptr]  <= mc_rq_rtnctl;
      end
      if (pop) begin
         if (q_wr[rd_ptr])
            store[q_idx[rd_ptr]] <= q_data[rd_ptr];
         rsp_cmd_p1  <= head_cmd;
         rsp_data_p1 <= head_data;
         rsp_rtn_p1  <= head_rtn;
      end
   end

   // ---- control: queue pointers, latency FSM and registered response outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         cnt          <= 8'd0;
         mc_rq_stall  <= 1'b0;
         err          <= 1'b0;
         mc_rs_vld    <= 1'b0;
         mc_rs_cmd    <= 3'd0;
         mc_rs_rtnctl <= '0;
         mc_rs_data   <= 64'd0;
      end else begin
         count <= count_next;
         // Two free slots absorb the initiator's registered stall sample
         // plus its registered valid.
         mc_rq_stall <= (count_next >= QHIWAT);
         if (mem_gnt) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         if (drop)    err    <= 1'b1;

         if (pop) begin
            // Pop cycle counts as the first of pop_lat cycles before mc_rs_vld.
            if (pop_lat == 8'd1) begin
               state        <= S_RESP;
               mc_rs_vld    <= 1'b1;
               mc_rs_cmd    <= head_cmd;
               mc_rs_rtnctl <= head_rtn;
               mc_rs_data   <= head_data;
            end else begin
               state     <= S_BUSY;
               cnt       <= pop_lat - 8'd1;
               mc_rs_vld <= 1'b0;
            end
         end else begin
            case (state)
               S_BUSY: begin
                  if (cnt == 8'd1) begin
                     state        <= S_RESP;
                     mc_rs_vld    <= 1'b1;
                     mc_rs_cmd    <= rsp_cmd_p1;
                     mc_rs_rtnctl <= rsp_rtn_p1;
                     mc_rs_data   <= rsp_data_p1;
                  end else begin
                     cnt <= cnt - 8'd1;
                  end
               end
               S_RESP: begin
                  if (!mc_rs_stall) begin
                     mc_rs_vld <= 1'b0;
                     state     <= S_IDLE;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mc_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mc_mem_responder
//   Self-checking bench for mc_mem_responder (default build, fixed latency).
//   A transaction-level model (word array plus an in-order queue of expected
//   responses) predicts every response; a negedge monitor compares them.
// ---------------------------------------------------------------------------
module tb_mc_mem_responder;

   localparam int RW     = 32;
   localparam int NAB    = 6;
   localparam int NWORDS = 64;
   localparam int QDEPTH = 4;
   localparam int LAT    = 3;

   localparam logic [2:0] C_IDLE     = 3'd0;
   localparam logic [2:0] C_RD8      = 3'd1;
   localparam logic [2:0] C_WR8      = 3'd2;
   localparam logic [2:0] R_RD8_DATA = 3'd2;
   localparam logic [2:0] R_WR_CMP   = 3'd3;
   localparam logic [47:0] BASE      = 48'h1234_5678_9A00;

   logic          clk = 1'b0;
   logic          rst;
   logic [47:0]   base_addr;
   logic          mc_rq_vld;
   logic [2:0]    mc_rq_cmd;
   logic [3:0]    mc_rq_scmd;
   logic [47:0]   mc_rq_vadr;
   logic [1:0]    mc_rq_size;
   logic [RW-1:0] mc_rq_rtnctl;
   logic [63:0]   mc_rq_data;
   logic          mc_rq_flush;
   logic          mc_rq_stall;
   logic          mem_gnt;
   logic          mc_rs_vld;
   logic [2:0]    mc_rs_cmd;
   logic [3:0]    mc_rs_scmd;
   logic [RW-1:0] mc_rs_rtnctl;
   logic [63:0]   mc_rs_data;
   logic          mc_rs_stall;
   logic          err;

   mc_mem_responder #(
      .MC_RTNCTL_WIDTH(RW), .NAB(NAB), .QDEPTH(QDEPTH), .LAT(LAT)
   ) dut (
      .clk(clk), .rst(rst), .base_addr(base_addr),
      .mc_rq_vld(mc_rq_vld), .mc_rq_cmd(mc_rq_cmd), .mc_rq_scmd(mc_rq_scmd),
      .mc_rq_vadr(mc_rq_vadr), .mc_rq_size(mc_rq_size), .mc_rq_rtnctl(mc_rq_rtnctl),
      .mc_rq_data(mc_rq_data), .mc_rq_flush(mc_rq_flush), .mc_rq_stall(mc_rq_stall),
      .mem_gnt(mem_gnt), .mc_rs_vld(mc_rs_vld), .mc_rs_cmd(mc_rs_cmd),
      .mc_rs_scmd(mc_rs_scmd), .mc_rs_rtnctl(mc_rs_rtnctl), .mc_rs_data(mc_rs_data),
      .mc_rs_stall(mc_rs_stall), .err(err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int n_rsp = 0;
   bit saw_stall = 0;

   typedef struct {
      logic [2:0]    cmd;
      logic [RW-1:0] rtn;
      logic [63:0]   data;
      bit            dk;
   } rsp_t;

   rsp_t        exp_q[$];
   logic [63:0] mem_m [NWORDS];
   bit          mem_k [NWORDS];

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Reference: in-order service, word index = ((vadr-base)>>3) mod 2^NAB.
   task automatic model_push(input logic [2:0] cmd, input logic [47:0] off,
                             input logic [63:0] d, input logic [RW-1:0] rtn);
      int   idx;
      rsp_t e;
      idx   = int'((off >> 3) % NWORDS);
      e.rtn = rtn;
      if (cmd == C_WR8) begin
         mem_m[idx] = d;
         mem_k[idx] = 1;
         e.cmd  = R_WR_CMP;
         e.data = 64'd0;
         e.dk   = 1;
      end else begin
         e.cmd  = R_RD8_DATA;
         e.data = mem_m[idx];
         e.dk   = mem_k[idx];
      end
      exp_q.push_back(e);
   endtask

   task automatic drive(input logic [2:0] cmd, input logic [47:0] off,
                        input logic [63:0] d, input logic [RW-1:0] rtn);
      mc_rq_vld    = 1'b1;
      mc_rq_cmd    = cmd;
      mc_rq_vadr   = BASE + off;
      mc_rq_data   = d;
      mc_rq_rtnctl = rtn;
      mc_rq_scmd   = 4'($urandom);
      mc_rq_size   = 2'($urandom);
      mc_rq_flush  = 1'($urandom);
   endtask

   // One request in the next cycle regardless of stall; checks mem_gnt.
   task automatic issue(input logic [2:0] cmd, input logic [47:0] off, input logic [63:0] d,
                        input logic [RW-1:0] rtn, input bit exp_g, input string tag);
      @(posedge clk); #1;
      drive(cmd, off, d, rtn);
      @(negedge clk);
      check({tag, "_gnt"}, mem_gnt, exp_g);
      if (exp_g) model_push(cmd, off, d, rtn);
   endtask

   // One request, waiting while mc_rq_stall is high (well-behaved initiator).
   task automatic issue_h(input logic [2:0] cmd, input logic [47:0] off, input logic [63:0] d,
                          input logic [RW-1:0] rtn, input bit rand_rs);
      int k = 0;
      bit exp_g;
      @(posedge clk); #1;
      while (mc_rq_stall && k < 100) begin
         saw_stall = 1;
         mc_rq_vld = 1'b0;
         mc_rq_cmd = C_IDLE;
         if (rand_rs) mc_rs_stall = ($urandom_range(0, 3) == 0);
         @(posedge clk); #1;
         k++;
      end
      check("stall_wait", k < 100, 1);
      if (rand_rs) mc_rs_stall = ($urandom_range(0, 3) == 0);
      drive(cmd, off, d, rtn);
      @(negedge clk);
      exp_g = (cmd == C_RD8) || (cmd == C_WR8);
      check("gnt_h", mem_gnt, exp_g);
      if (exp_g) model_push(cmd, off, d, rtn);
   endtask

   task automatic idle_in();
      @(posedge clk); #1;
      mc_rq_vld = 1'b0;
      mc_rq_cmd = C_IDLE;
   endtask

   task automatic drain(input string tag, input int budget);
      int k = 0;
      mc_rs_stall = 1'b0;
      while ((exp_q.size() != 0 || mc_rs_vld) && k < budget) begin
         @(posedge clk); #1;
         k++;
      end
      check({tag, "_drain"}, k < budget, 1);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_rs_vld"}, mc_rs_vld, 0);
      check({tag, "_rs_cmd"}, mc_rs_cmd, 0);
      check({tag, "_rs_scmd"}, mc_rs_scmd, 0);
      check({tag, "_rs_rtn"}, mc_rs_rtnctl, 0);
      check({tag, "_rs_data"}, mc_rs_data, 0);
      check({tag, "_rq_stall"}, mc_rq_stall, 0);
      check({tag, "_gnt"}, mem_gnt, 0);
      check({tag, "_err"}, err, 0);
   endtask

   // Response monitor: consumption when vld & ~stall, stability while stalled.
   always @(negedge clk) begin
      rsp_t e;
      if (!rst && mc_rs_vld) begin
         if (exp_q.size() == 0) begin
            check("unexpected_rsp", mc_rs_vld, 0);
         end else begin
            e = exp_q[0];
            check(mc_rs_stall ? "held_cmd" : "rsp_cmd", mc_rs_cmd, e.cmd);
            check(mc_rs_stall ? "held_rtn" : "rsp_rtn", mc_rs_rtnctl, e.rtn);
            if (e.dk) check(mc_rs_stall ? "held_data" : "rsp_data", mc_rs_data, e.data);
            check("rsp_scmd", mc_rs_scmd, 0);
            if (!mc_rs_stall) begin
               void'(exp_q.pop_front());
               n_rsp++;
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int k;
      int base_n;
      rst = 1'b1; base_addr = BASE; mc_rq_vld = 1'b0; mc_rq_cmd = C_IDLE;
      mc_rq_scmd = 4'd0; mc_rq_vadr = 48'd0; mc_rq_size = 2'd0; mc_rq_rtnctl = '0;
      mc_rq_data = 64'd0; mc_rq_flush = 1'b0; mc_rs_stall = 1'b0;
      for (int i = 0; i < NWORDS; i++) mem_k[i] = 0;

      #2;
      check_zero("reset");
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Test 1: WR8 latency and WR_CMP content
      issue(C_WR8, 48'h18, 64'hDEAD_BEEF, 32'd2, 1'b1, "t1");
      idle_in();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("t1_lat_early", mc_rs_vld, 0);
      @(posedge clk);
      @(negedge clk);
      check("t1_lat", mc_rs_vld, 1);
      drain("t1", 50);

      // Test 2: read-after-write
      issue(C_RD8, 48'h18, 64'd0, 32'd1, 1'b1, "t2");
      idle_in();
      drain("t2", 50);

      // Fill the whole store so later random reads have known data
      for (int i = 0; i < NWORDS; i++)
         issue_h(C_WR8, 48'(i * 8), {$urandom, $urandom}, RW'(i), 1'b0);
      idle_in();
      drain("init", 200);

      // Index wrap: above the store and below base_addr
      issue(C_RD8, 48'(NWORDS * 8 + 8'h18 + 5), 64'd0, 32'h100, 1'b1, "wrap_hi");
      issue(C_RD8, 48'hFFFF_FFFF_FFF8, 64'd0, 32'h101, 1'b1, "wrap_lo");
      idle_in();
      drain("wrap", 50);

      // Test 3: six back-to-back RD8 honouring stall
      saw_stall = 0;
      for (int i = 0; i < 6; i++)
         issue_h(C_RD8, 48'h18, 64'd0, RW'(16 + i), 1'b0);
      idle_in();
      check("t3_saw_stall", saw_stall, 1);
      drain("t3", 100);
      check("t3_err", err, 0);

      // Test 5: response held 5 cycles under mc_rs_stall
      mc_rs_stall = 1'b1;
      issue(C_WR8, 48'd40, {$urandom, $urandom}, 32'h55, 1'b1, "t5");
      idle_in();
      k = 0;
      while (!mc_rs_vld && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      check("t5_rs_vld_seen", k < 20, 1);
      base_n = n_rsp;
      repeat (5) begin
         @(negedge clk);
         check("t5_hold_vld", mc_rs_vld, 1);
      end
      check("t5_none_yet", n_rsp, base_n);
      drain("t5", 50);
      check("t5_one_rsp", n_rsp, base_n + 1);

      // Random traffic, honouring stall, random consumer back-pressure
      for (int n = 0; n < 300; n++) begin
         int r;
         logic [2:0] c;
         r = $urandom_range(0, 9);
         c = (r < 4) ? C_RD8 : ((r < 8) ? C_WR8 : C_IDLE);
         issue_h(c, {16'($urandom), 32'($urandom)}, {$urandom, $urandom}, RW'($urandom), 1'b1);
      end
      idle_in();
      drain("rand", 500);
      check("rand_err", err, 0);

      // Test 4: ignore stall, 8 back-to-back RD8 while the response is held
      mc_rs_stall = 1'b1;
      base_n = n_rsp;
      for (int i = 0; i < 8; i++)
         issue(C_RD8, 48'h18, 64'd0, RW'(64 + i), i < 5, "t4");
      idle_in();
      @(negedge clk);
      check("t4_err", err, 1);
      drain("t4", 100);
      check("t4_rsp_count", n_rsp, base_n + 5);
      check("t4_err_sticky", err, 1);

      // Test 6: asynchronous reset with requests queued
      mc_rs_stall = 1'b1;
      for (int i = 0; i < 4; i++)
         issue(C_WR8, 48'((7 + i) * 8), {$urandom, $urandom}, RW'(96 + i), 1'b1, "t6");
      idle_in();
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check_zero("t6_rst");
      exp_q.delete();
      for (int i = 7; i < 11; i++) mem_k[i] = 0;
      @(negedge clk);
      rst = 1'b0;
      mc_rs_stall = 1'b0;
      base_n = n_rsp;
      repeat (20) @(posedge clk);
      @(negedge clk);
      check("t6_no_rsp", n_rsp, base_n);
      check("t6_rs_vld", mc_rs_vld, 0);

      // Unsupported command is dropped and flagged; IDLE is a no-op
      issue(C_IDLE, 48'd0, 64'd0, '0, 1'b0, "idle_cmd");
      idle_in();
      @(negedge clk);
      check("idle_cmd_err", err, 0);
      issue(3'd5, 48'd0, 64'd0, '0, 1'b0, "bad_cmd");
      idle_in();
      @(negedge clk);
      check("bad_cmd_err", err, 1);
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("bad_cmd_no_rsp", n_rsp, base_n);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
